mem_access_stage: RTL

//  Parametrised memory-access stage of the 5-stage pipeline; successor to the fixed 64-bit, single-cycle MEM stage.

---
 rtl/mem_stage_pkg.sv | 36 +++
 rtl/mem_access_stage_load_extend.sv | 32 +++
 rtl/mem_access_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and the alignment rule for the memory-access pipeline stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HALF  = 2'b01,
        WORD  = 2'b10,
        DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        SRC_MEM   = 2'b00,
        SRC_MUL   = 2'b01,
        SRC_ALU   = 2'b10,
        SRC_SHIFT = 2'b11
    } wr_src_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // A dword access is only legal on a 64-bit datapath.
    function automatic logic is_aligned(input logic [2:0] addr_lo, input size_e size,
                                        input int data_w);
        logic ok;
        case (size)
            BYTE:    ok = 1'b1;
            HALF:    ok = (addr_lo[0] == 1'b0);
            WORD:    ok = (addr_lo[1:0] == 2'b00);
            default: ok = (addr_lo == 3'b000) && (data_w == 64);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Narrows lane-0 read data to the access size and sign/zero-extends it to DATA_W.
module load_extend
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] rdata,
    input  size_e             size,
    input  logic              is_signed,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = rdata;
        case (size)
            BYTE: begin
                if (is_signed) data = DATA_W'($signed(rdata[7:0]));
                else           data = DATA_W'(rdata[7:0]);
            end
            HALF: begin
                if (is_signed) data = DATA_W'($signed(rdata[15:0]));
                else           data = DATA_W'(rdata[15:0]);
            end
            WORD: begin
                if (is_signed) data = DATA_W'($signed(rdata[31:0]));
                else           data = DATA_W'(rdata[31:0]);
            end
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues handshaked loads/stores, stalls while waiting, and
// registers the write-back slot into MEM/WB.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [1:0]            ex_size,
    input  logic                  ex_signed,
    input  logic [1:0]            ex_wr_src,
    input  logic [DATA_W-1:0]     ex_alu,
    input  logic [DATA_W-1:0]     ex_mul,
    input  logic [DATA_W-1:0]     ex_shift,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [1:0]            mem_size,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall,
    output logic                  fwd_valid,
    output logic [DATA_W-1:0]     fwd_data,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  err_misalign,
    output logic                  err_timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            state;
    logic [CNT_W-1:0]  wait_cnt;
    size_e             size;
    wr_src_e           wr_src;
    logic [ADDR_W-1:0] addr;
    logic              mem_op;
    logic              aligned;
    logic              access;
    logic              misalign;
    logic              timeout_hit;
    logic              abort;
    logic [DATA_W-1:0] load_data;

    assign size    = size_e'(ex_size);
    assign wr_src  = wr_src_e'(ex_wr_src);
    assign addr    = ADDR_W'(ex_alu);

    assign mem_op   = ex_valid & (ex_mem_read | ex_mem_write);
    assign aligned  = is_aligned(addr[2:0], size, DATA_W);
    assign access   = mem_op & aligned;
    assign misalign = mem_op & ~aligned;

    // The last permitted wait cycle releases the stall so the aborted slot can drain.
    assign timeout_hit = (TIMEOUT != 0) && (state == WAIT) &&
                         (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign abort       = access & ~mem_ack & timeout_hit;

    assign mem_req   = ~reset & access;
    assign mem_we    = ex_mem_write;
    assign mem_addr  = addr;
    assign mem_size  = ex_size;
    assign mem_wdata = ex_store_data;
    assign stall     = ~reset & access & ~mem_ack & ~timeout_hit;

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .rdata     (mem_rdata),
        .size      (size),
        .is_signed (ex_signed),
        .data      (load_data)
    );

    always_comb begin
        fwd_data = ex_alu;
        case (wr_src)
            SRC_MEM:   fwd_data = load_data;
            SRC_MUL:   fwd_data = ex_mul;
            SRC_ALU:   fwd_data = ex_alu;
            SRC_SHIFT: fwd_data = ex_shift;
            default:   fwd_data = ex_alu;
        endcase
    end

    assign fwd_valid = ex_valid & ex_reg_write & ~stall;

    // A stalled edge inserts a bubble but keeps wb_rd/wb_data for the hazard logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_misalign <= misalign;
            err_timeout  <= abort;
            case (state)
                IDLE: begin
                    if (access && !mem_ack) state <= WAIT;
                end
                WAIT: begin
                    if (!access || mem_ack || timeout_hit) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
            endcase
            if (stall) begin
                wb_valid     <= 1'b0;
                wb_reg_write <= 1'b0;
            end else begin
                wb_valid     <= ex_valid;
                wb_reg_write <= ex_reg_write & ~(misalign | abort);
                wb_rd        <= ex_rd;
                wb_data      <= fwd_data;
            end
        end
    end

endmodule
